// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R1W register file with a hardware clear sequencer
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward a same-cycle write to the read ports.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              reg_write,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    logic              busy_q;
    logic [ADDR_W:0]   clr_idx;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              write_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    function automatic logic addr_is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        write_ok = reg_write && !busy_q && addr_in_range(write_reg)
                   && !addr_is_zero_reg(write_reg);
    end

    // The sweep and the write port share the single memory write port; they never
    // overlap because user writes are dropped while the sweep runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = write_reg;
        mem_wdata = write_data;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_idx[ADDR_W-1:0];
                mem_wdata = '0;
            end else if (write_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    clr_idx <= clr_idx + (ADDR_W + 1)'(1);
                end
            endcase
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] d;
        d = '0;
        if (!busy_q && addr_in_range(a) && !addr_is_zero_reg(a)) begin
            d = mem[a];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (write_ok && (write_reg == a)) begin
                d = write_data;
            end
`endif
        end
        return d;
    endfunction

    always_comb begin
        read_data1 = read_port(readreg1);
        read_data2 = read_port(readreg2);
    end

    assign busy = busy_q;

endmodule
